// File: rtl/shadow_dcache_arbiter.sv
// shadow_dcache_arbiter
// Shares one data-cache request port between three requesters:
//   0 = shadow-register save engine (stores)
//   1 = shadow-register load engine (loads)
//   2 = load unit
// Loads use a two-phase protocol: request phase (req/gnt) followed one
// cycle later by the tag phase (tag_valid/tag/kill_req). In-order load
// responses are routed back to their issuer through an owner/id FIFO.
// Optional feature macro: SHADOW_ARB_AGE_EN (load-unit age promotion).

package shadow_dcache_arbiter_pkg;

   localparam int unsigned INDEX_W = 12;
   localparam int unsigned TAG_W   = 20;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned USER_W  = 1;
   localparam int unsigned ID_W    = 4;

   typedef struct packed {
      int unsigned DcacheIndexWidth;
      int unsigned DcacheTagWidth;
      int unsigned DcacheIdWidth;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{
      DcacheIndexWidth: INDEX_W,
      DcacheTagWidth:   TAG_W,
      DcacheIdWidth:    ID_W
   };

   typedef struct packed {
      logic [INDEX_W-1:0]  address_index;
      logic [TAG_W-1:0]    address_tag;
      logic [DATA_W-1:0]   data_wdata;
      logic [USER_W-1:0]   data_wuser;
      logic                data_req;
      logic                data_we;
      logic [DATA_W/8-1:0] data_be;
      logic [1:0]          data_size;
      logic [ID_W-1:0]     data_id;
      logic                kill_req;
      logic                tag_valid;
   } dcache_req_i_t;

   typedef struct packed {
      logic                data_gnt;
      logic                data_rvalid;
      logic [ID_W-1:0]     data_rid;
      logic [DATA_W-1:0]   data_rdata;
   } dcache_req_o_t;

endpackage

// Protocol and configuration checks for the arbiter.
module shadow_dcache_arbiter_chk #(
   parameter int unsigned NUM_REQ         = 3,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned AGE_LIMIT       = 8
) (
   input logic clk_i,
   input logic rst_ni,
   input logic rvalid_i,
   input logic fifo_empty_i,
   input logic fifo_full_i,
   input logic push_i,
   input logic pop_i
);

   // Configuration must be 3 requesters and a power-of-two FIFO depth >= 2.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (NUM_REQ == 3) && (MAX_OUTSTANDING >= 2) &&
      ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) == 0) && (AGE_LIMIT >= 1))
      else $error("shadow_dcache_arbiter: illegal parameter configuration");

   // A response with nothing outstanding is dropped by the arbiter.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(rvalid_i && fifo_empty_i))
      else $error("shadow_dcache_arbiter: rvalid with no outstanding load");

   // Load eligibility must keep the routing FIFO from overflowing.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && fifo_full_i && !pop_i))
      else $error("shadow_dcache_arbiter: push into full routing FIFO");

endmodule

module shadow_dcache_arbiter #(
   parameter shadow_dcache_arbiter_pkg::cva6_cfg_t CVA6Cfg =
      shadow_dcache_arbiter_pkg::cva6_cfg_empty,
   parameter type dcache_req_i_t = shadow_dcache_arbiter_pkg::dcache_req_i_t,
   parameter type dcache_req_o_t = shadow_dcache_arbiter_pkg::dcache_req_o_t,
   parameter int unsigned NUM_REQ         = 3,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned AGE_LIMIT       = 8
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  dcache_req_i_t                      req_ports_i [NUM_REQ-1:0],
   output dcache_req_o_t                      req_ports_o [NUM_REQ-1:0],
   output dcache_req_i_t                      dcache_req_o,
   input  dcache_req_o_t                      dcache_req_i,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
   output logic                               busy_o
);

   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned IdW   = CVA6Cfg.DcacheIdWidth;

   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W:0]   OCC_MAX = (CNT_W + 1)'(MAX_OUTSTANDING);

   // Arbitration
   logic [NUM_REQ-1:0] elig_s;
   logic [1:0]         win_s;
   logic               any_s;
   logic               gnt_s;
   logic               promote_s;
   logic               load_room_s;
   logic [CNT_W:0]     occ_s;

   // Tag phase
   logic               tag_pending_q, tag_pending_d;
   logic [1:0]         owner_q, owner_d;
   logic [IdW-1:0]     tid_q, tid_d;

   // Routing FIFO
   logic [1:0]         fifo_owner_q [MAX_OUTSTANDING];
   logic [IdW-1:0]     fifo_id_q    [MAX_OUTSTANDING];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               push_s, pop_s;
   logic [1:0]         head_owner_s;
   logic [IdW-1:0]     head_id_s;

   // The cache echoes an id, but the stored id is authoritative.
   logic               unused_s;
   assign unused_s = ^dcache_req_i.data_rid;

   // Loads may be accepted only while the FIFO plus the pending tag phase
   // leaves room; a pop in this cycle frees a slot immediately.
   assign pop_s  = rst_ni && dcache_req_i.data_rvalid && (cnt_q != '0);
   assign push_s = tag_pending_q && !req_ports_i[owner_q].kill_req;
   assign occ_s  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, tag_pending_q}
                 - {{CNT_W{1'b0}}, pop_s};
   assign load_room_s = (occ_s < OCC_MAX);

   assign head_owner_s = fifo_owner_q[rd_ptr_q];
   assign head_id_s    = fifo_id_q[rd_ptr_q];

   // Eligibility and priority selection of the request-phase winner.
   always_comb begin
      elig_s = '0;
      win_s  = 2'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rst_ni && req_ports_i[i].data_req &&
             (req_ports_i[i].data_we || load_room_s)) begin
            elig_s[i] = 1'b1;
         end else begin
            elig_s[i] = 1'b0;
         end
      end
      if (promote_s && elig_s[2]) begin
         win_s = 2'd2;
      end else if (elig_s[0]) begin
         win_s = 2'd0;
      end else if (elig_s[1]) begin
         win_s = 2'd1;
      end else if (elig_s[2]) begin
         win_s = 2'd2;
      end else begin
         win_s = 2'd0;
      end
   end

   assign any_s = |elig_s;
   assign gnt_s = any_s && dcache_req_i.data_gnt;

`ifdef SHADOW_ARB_AGE_EN
   localparam int unsigned      AGE_W   = $clog2(AGE_LIMIT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);
   localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

   logic [AGE_W-1:0] age_q, age_d;

   assign promote_s = (age_q >= AGE_MAX);

   // Load-unit age: count cycles it waits while eligible, clear on grant.
   always_comb begin
      age_d = age_q;
      if (gnt_s && (win_s == 2'd2)) begin
         age_d = '0;
      end else if (elig_s[2] && (age_q < AGE_MAX)) begin
         age_d = age_q + AGE_ONE;
      end else begin
         age_d = age_q;
      end
   end

   // Load-unit age register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         age_q <= '0;
      end else begin
         age_q <= age_d;
      end
   end
`else
   assign promote_s = 1'b0;
`endif

   // Merged cache request: request fields from the winner, tag fields from
   // the owner of last cycle's granted load.
   always_comb begin
      dcache_req_o               = '0;
      dcache_req_o.address_index = req_ports_i[win_s].address_index;
      dcache_req_o.data_wdata    = req_ports_i[win_s].data_wdata;
      dcache_req_o.data_wuser    = req_ports_i[win_s].data_wuser;
      dcache_req_o.data_we       = req_ports_i[win_s].data_we;
      dcache_req_o.data_be       = req_ports_i[win_s].data_be;
      dcache_req_o.data_size     = req_ports_i[win_s].data_size;
      dcache_req_o.data_id       = req_ports_i[win_s].data_id;
      dcache_req_o.data_req      = any_s;
      dcache_req_o.address_tag   = req_ports_i[owner_q].address_tag;
      if (tag_pending_q) begin
         dcache_req_o.tag_valid = req_ports_i[owner_q].tag_valid;
         dcache_req_o.kill_req  = req_ports_i[owner_q].kill_req;
      end else begin
         dcache_req_o.tag_valid = 1'b0;
         dcache_req_o.kill_req  = 1'b0;
      end
   end

   // Per-requester grant forwarding and in-order response routing.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ports_o[i] = '0;
         if (gnt_s && (win_s == 2'(i))) begin
            req_ports_o[i].data_gnt = 1'b1;
         end else begin
            req_ports_o[i].data_gnt = 1'b0;
         end
         if (pop_s && (head_owner_s == 2'(i))) begin
            req_ports_o[i].data_rvalid = 1'b1;
            req_ports_o[i].data_rdata  = dcache_req_i.data_rdata;
            req_ports_o[i].data_rid    = head_id_s;
         end else begin
            req_ports_o[i].data_rvalid = 1'b0;
         end
      end
   end

   // Arm the tag phase for exactly one cycle after each granted load.
   always_comb begin
      tag_pending_d = 1'b0;
      owner_d       = owner_q;
      tid_d         = tid_q;
      if (gnt_s && !req_ports_i[win_s].data_we) begin
         tag_pending_d = 1'b1;
         owner_d       = win_s;
         tid_d         = IdW'(req_ports_i[win_s].data_id);
      end else begin
         tag_pending_d = 1'b0;
      end
   end

   // FIFO pointer/count update; simultaneous push and pop keep the count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      busy_d = (cnt_d != '0) || tag_pending_d;
   end

   // Tag-phase, pointer, count and busy registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tag_pending_q <= 1'b0;
         owner_q       <= 2'd0;
         tid_q         <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         cnt_q         <= '0;
         busy_q        <= 1'b0;
      end else begin
         tag_pending_q <= tag_pending_d;
         owner_q       <= owner_d;
         tid_q         <= tid_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         cnt_q         <= cnt_d;
         busy_q        <= busy_d;
      end
   end

   // Routing FIFO storage: one {owner, id} entry per un-killed load.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            fifo_owner_q[i] <= 2'd0;
            fifo_id_q[i]    <= '0;
         end
      end else begin
         if (push_s) begin
            fifo_owner_q[wr_ptr_q] <= owner_q;
            fifo_id_q[wr_ptr_q]    <= tid_q;
         end
      end
   end

   assign outstanding_o = cnt_q;
   assign busy_o        = busy_q;

   shadow_dcache_arbiter_chk #(
      .NUM_REQ         (NUM_REQ),
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .AGE_LIMIT       (AGE_LIMIT)
   ) u_chk (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .rvalid_i     (dcache_req_i.data_rvalid),
      .fifo_empty_i (cnt_q == '0),
      .fifo_full_i  (cnt_q == CNT_W'(MAX_OUTSTANDING)),
      .push_i       (push_s),
      .pop_i        (pop_s)
   );

endmodule

// File: tb/tb_shadow_dcache_arbiter.sv
// Self-checking bench for shadow_dcache_arbiter. Responses are checked by a
// scoreboard monitor; request-side behaviour is checked cycle by cycle.
module tb_shadow_dcache_arbiter;

   typedef shadow_dcache_arbiter_pkg::dcache_req_i_t req_t;
   typedef shadow_dcache_arbiter_pkg::dcache_req_o_t rsp_t;

   typedef struct {
      int          port;
      logic [31:0] data;
      logic [3:0]  id;
   } exp_t;

   logic       clk;
   logic       rst_n;
   req_t       req_i [2:0];
   rsp_t       resp_o [2:0];
   req_t       dc_o;
   rsp_t       dc_i;
   logic [2:0] outstanding;
   logic       busy;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   shadow_dcache_arbiter #(
      .MAX_OUTSTANDING (4),
      .AGE_LIMIT       (8)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .req_ports_i   (req_i),
      .req_ports_o   (resp_o),
      .dcache_req_o  (dc_o),
      .dcache_req_i  (dc_i),
      .outstanding_o (outstanding),
      .busy_o        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic req_t mk_req(input logic we, input logic [11:0] idx,
                                   input logic [31:0] wd, input logic [3:0] id,
                                   input logic [19:0] tag);
      req_t r;
      r               = '0;
      r.data_req      = 1'b1;
      r.data_we       = we;
      r.address_index = idx;
      r.data_wdata    = wd;
      r.data_be       = 4'hF;
      r.data_size     = 2'd2;
      r.data_id       = id;
      r.address_tag   = tag;
      r.tag_valid     = 1'b1;
      r.kill_req      = 1'b0;
      return r;
   endfunction

   // Expected response goes into the scoreboard, then the cache returns it.
   task automatic send_rsp(input int p, input logic [31:0] d, input logic [3:0] id);
      exp_t e;
      e.port = p;
      e.data = d;
      e.id   = id;
      exp_q.push_back(e);
      dc_i.data_rvalid = 1'b1;
      dc_i.data_rdata  = d;
      dc_i.data_rid    = ~id;
   endtask

   task automatic idle_all();
      for (int i = 0; i < 3; i++) req_i[i] = '0;
      dc_i = '0;
   endtask

   // Scoreboard monitor: every rvalid seen on a requester port is matched.
   always @(negedge clk) begin
      for (int p = 0; p < 3; p++) begin
         if (resp_o[p].data_rvalid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rsp_unexpected: port %0d rvalid, scoreboard empty", p);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.port != p || resp_o[p].data_rdata !== mon_e.data ||
                   resp_o[p].data_rid !== mon_e.id) begin
                  n_fail++;
                  $display("FAIL rsp_route: got port %0d data %h id %0d, expected port %0d data %h id %0d",
                           p, resp_o[p].data_rdata, resp_o[p].data_rid,
                           mon_e.port, mon_e.data, mon_e.id);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  first_g;
      bit  lsu_req;
      bit  ok;

      rst_n = 1'b0;
      idle_all();
      @(negedge clk);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data_req", dc_o.data_req, 0);
      chk("rst_tag_valid", dc_o.tag_valid, 0);
      chk("rst_kill", dc_o.kill_req, 0);
      chk("rst_gnt2", resp_o[2].data_gnt, 0);
      step();
      rst_n = 1'b1;
      step();

      // Lone LSU load: grant, tag phase next cycle, response at cycle 3.
      req_i[2] = mk_req(1'b0, 12'h123, 32'h0, 4'd1, 20'hABCDE);
      dc_i.data_gnt = 1'b1;
      @(negedge clk);
      chk("t1_data_req", dc_o.data_req, 1);
      chk("t1_index", dc_o.address_index, 12'h123);
      chk("t1_gnt2", resp_o[2].data_gnt, 1);
      chk("t1_gnt0", resp_o[0].data_gnt, 0);
      chk("t1_no_tag_c0", dc_o.tag_valid, 0);
      step();
      req_i[2].data_req = 1'b0;
      dc_i.data_gnt = 1'b0;
      @(negedge clk);
      chk("t1_tag_valid", dc_o.tag_valid, 1);
      chk("t1_tag", dc_o.address_tag, 20'hABCDE);
      chk("t1_busy", busy, 1);
      step();
      @(negedge clk);
      chk("t1_outstanding_1", outstanding, 1);
      chk("t1_tag_clear", dc_o.tag_valid, 0);
      step();
      send_rsp(2, 32'hDEADBEEF, 4'd1);
      step();
      dc_i.data_rvalid = 1'b0;
      @(negedge clk);
      chk("t1_outstanding_0", outstanding, 0);
      chk("t1_busy_0", busy, 0);
      step();

      // Winner without cache grant is replaced by a higher-priority requester.
      req_i[2] = mk_req(1'b0, 12'h0AA, 32'h0, 4'd3, 20'h00333);
      @(negedge clk);
      chk("rp_data_req", dc_o.data_req, 1);
      chk("rp_index_lsu", dc_o.address_index, 12'h0AA);
      chk("rp_gnt2_nogrant", resp_o[2].data_gnt, 0);
      step();
      req_i[0] = mk_req(1'b1, 12'h0BB, 32'h12345678, 4'd0, 20'h0);
      @(negedge clk);
      chk("rp_index_save", dc_o.address_index, 12'h0BB);
      chk("rp_gnt0_nogrant", resp_o[0].data_gnt, 0);
      step();
      dc_i.data_gnt = 1'b1;
      @(negedge clk);
      chk("rp_gnt0", resp_o[0].data_gnt, 1);
      chk("rp_gnt2_lost", resp_o[2].data_gnt, 0);
      step();
      req_i[0] = '0;
      @(negedge clk);
      chk("rp_gnt2", resp_o[2].data_gnt, 1);
      step();
      req_i[2].data_req = 1'b0;
      dc_i.data_gnt = 1'b0;
      step();
      send_rsp(2, 32'hCAFE0003, 4'd3);
      step();
      dc_i.data_rvalid = 1'b0;
      step();

      // Save store vs shadow load with cache gnt every cycle.
      dc_i.data_gnt = 1'b1;
      req_i[1] = mk_req(1'b0, 12'h020, 32'h0, 4'd2, 20'h00222);
      for (int k = 0; k < 3; k++) begin
         req_i[0] = mk_req(1'b1, 12'h010, 32'h11110000 * (k + 1), 4'd0, 20'h0);
         @(negedge clk);
         chk("t2_gnt0", resp_o[0].data_gnt, 1);
         chk("t2_gnt1", resp_o[1].data_gnt, 0);
         chk("t2_wdata", dc_o.data_wdata, 32'h11110000 * (k + 1));
         chk("t2_we", dc_o.data_we, 1);
         chk("t2_no_tag", dc_o.tag_valid, 0);
         step();
      end
      req_i[0] = '0;
      @(negedge clk);
      chk("t2_gnt1_after", resp_o[1].data_gnt, 1);
      chk("t2_index1", dc_o.address_index, 12'h020);
      chk("t2_no_tag_store", dc_o.tag_valid, 0);
      step();
      req_i[1].data_req = 1'b0;
      @(negedge clk);
      chk("t2_idle_req", dc_o.data_req, 0);
      chk("t2_idle_gnt1", resp_o[1].data_gnt, 0);
      chk("t2_load_tag", dc_o.tag_valid, 1);
      step();
      send_rsp(1, 32'h0BADF00D, 4'd2);
      step();
      dc_i.data_rvalid = 1'b0;
      step();

      // Four back-to-back shadow loads fill the FIFO; fifth waits for a pop.
      for (int k = 0; k < 4; k++) begin
         req_i[1] = mk_req(1'b0, 12'h100 + 12'(k), 32'h0, 4'(k), 20'h01000);
         @(negedge clk);
         chk("t3_gnt", resp_o[1].data_gnt, 1);
         step();
      end
      req_i[1] = mk_req(1'b0, 12'h104, 32'h0, 4'd4, 20'h01000);
      @(negedge clk);
      chk("t3_full_req", dc_o.data_req, 0);
      chk("t3_full_gnt", resp_o[1].data_gnt, 0);
      step();
      @(negedge clk);
      chk("t3_outstanding_4", outstanding, 4);
      chk("t3_blocked", dc_o.data_req, 0);
      step();
      send_rsp(1, 32'hA0A0A0A0, 4'd0);
      @(negedge clk);
      chk("t3_pop_gnt", resp_o[1].data_gnt, 1);
      step();
      req_i[1].data_req = 1'b0;
      send_rsp(1, 32'hA1A1A1A1, 4'd1);
      step();
      for (int k = 2; k <= 4; k++) begin
         if (k == 2) begin
            @(negedge clk);
            chk("t3_push_pop", outstanding, 3);
         end
         send_rsp(1, 32'hA0A0A0A0 + 32'(k) * 32'h01010101, 4'(k));
         step();
      end
      dc_i.data_rvalid = 1'b0;
      @(negedge clk);
      chk("t3_drained", outstanding, 0);
      step();

      // LSU load killed in its tag phase, followed by a shadow load.
      req_i[2] = mk_req(1'b0, 12'h0C0, 32'h0, 4'd5, 20'h00555);
      @(negedge clk);
      chk("t4_gnt2", resp_o[2].data_gnt, 1);
      step();
      req_i[2].data_req = 1'b0;
      req_i[2].kill_req = 1'b1;
      req_i[1] = mk_req(1'b0, 12'h0D0, 32'h0, 4'd6, 20'h00666);
      @(negedge clk);
      chk("t4_kill", dc_o.kill_req, 1);
      chk("t4_b2b_gnt1", resp_o[1].data_gnt, 1);
      step();
      req_i[1].data_req = 1'b0;
      req_i[2].kill_req = 1'b0;
      @(negedge clk);
      chk("t4_tag_shadow", dc_o.address_tag, 20'h00666);
      chk("t4_no_kill", dc_o.kill_req, 0);
      step();
      send_rsp(1, 32'h600DCAFE, 4'd6);
      @(negedge clk);
      chk("t4_only_one", outstanding, 1);
      step();
      dc_i.data_rvalid = 1'b0;
      @(negedge clk);
      chk("t4_drained", outstanding, 0);
      step();

      // Asynchronous reset with two loads outstanding.
      req_i[1] = mk_req(1'b0, 12'h0E0, 32'h0, 4'd1, 20'h00777);
      step();
      req_i[1].data_id = 4'd2;
      step();
      req_i[1].data_req = 1'b0;
      step();
      @(negedge clk);
      chk("t5_outstanding_2", outstanding, 2);
      step();
      req_i[1].data_req = 1'b1;
      #2;
      rst_n = 1'b0;
      dc_i.data_rvalid = 1'b1;
      dc_i.data_rdata  = 32'hFFFFFFFF;
      #1;
      chk("t5_outstanding", outstanding, 0);
      chk("t5_busy", busy, 0);
      chk("t5_gnt1", resp_o[1].data_gnt, 0);
      chk("t5_rvalid1", resp_o[1].data_rvalid, 0);
      chk("t5_data_req", dc_o.data_req, 0);
      idle_all();
      step();
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_after", outstanding, 0);
      step();

      // Continuous saves while the LSU waits.
      dc_i.data_gnt = 1'b1;
      req_i[2] = mk_req(1'b0, 12'h0F0, 32'h0, 4'd7, 20'h00888);
      first_g = -1;
      lsu_req = 1'b1;
      for (int k = 0; k < 12; k++) begin
         req_i[0] = mk_req(1'b1, 12'h011, 32'(k), 4'd0, 20'h0);
         req_i[2].data_req = lsu_req;
         @(negedge clk);
         if (resp_o[2].data_gnt === 1'b1) begin
            if (first_g < 0) first_g = k;
            lsu_req = 1'b0;
         end
         step();
      end
`ifdef SHADOW_ARB_AGE_EN
      chk("t6_age_first_grant", 64'(first_g), 64'(8));
`else
      chk("t6_no_grant_while_save", 64'(first_g), 64'(-1));
`endif
      req_i[0] = '0;
      req_i[2].data_req = lsu_req;
      if (lsu_req) begin
         ok = 1'b0;
         for (int k = 0; k < 5 && !ok; k++) begin
            @(negedge clk);
            if (resp_o[2].data_gnt === 1'b1) ok = 1'b1;
            step();
            if (ok) req_i[2].data_req = 1'b0;
         end
         chk("t6_grant_after_release", ok, 1);
      end
      ok = 1'b0;
      for (int k = 0; k < 5 && !ok; k++) begin
         @(negedge clk);
         if (outstanding == 3'd1) ok = 1'b1;
         step();
      end
      chk("t6_outstanding_1", ok, 1);
      send_rsp(2, 32'h5A5A5A5A, 4'd7);
      step();
      dc_i = '0;
      @(negedge clk);
      chk("t6_drained", outstanding, 0);
      step();

      chk("scoreboard_empty", 64'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
